// File: rtl/uw_sync_pkg.sv
// Shared types and default lock/timeout constants for the unique-word sync sequencer.
package uw_sync_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ARM,
    ST_REPLAY,
    ST_WAIT,
    ST_EVAL
  } uw_seq_state_t;

  localparam int LOCK_THRESH_DEF = 224;
  localparam int LOCK_COUNT_DEF  = 3;
  localparam int MISS_LIMIT_DEF  = 2;
  localparam int TIMEOUT_DEF     = 4096;

endpackage

// File: rtl/uw_sync_sequencer_if.sv
// Upstream hard-bit stream into the sequencer: valid/ready handshake with one data bit.
interface uw_sync_sequencer_if;

  logic hard_inp;
  logic valid_in;
  logic ready_out;

  modport master (output hard_inp, output valid_in, input ready_out);
  modport slave  (input hard_inp, input valid_in, output ready_out);

endinterface

// File: rtl/uw_bit_buffer.sv
// 1-bit x DEPTH simple dual-port RAM: one write port, one registered read port.
module uw_bit_buffer #(
  parameter int DEPTH = 2560,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uw_sync_sequencer.sv
// Captures one acquisition window, replays it gap-free to the UW correlator and
// runs lock/unlock hysteresis on the returned offset/rotation.
module uw_sync_sequencer
  import uw_sync_pkg::*;
#(
  parameter int BITS_PER_FRAME = 80,
  parameter int NUM_FRAMES     = 32,
  parameter int MAX_CORR_VAL   = 257,
  parameter int LOCK_THRESH    = LOCK_THRESH_DEF,
  parameter int LOCK_COUNT     = LOCK_COUNT_DEF,
  parameter int MISS_LIMIT     = MISS_LIMIT_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int OW             = $clog2(BITS_PER_FRAME),
  parameter int WW             = $clog2(MAX_CORR_VAL)
) (
  input  logic                 clk,
  input  logic                 rst_in_n,
  uw_sync_sequencer_if.slave   up,
  output logic                 corr_bit,
  output logic                 corr_valid,
  output logic                 corr_rst,
  input  logic                 corr_ready_rx,
  input  logic                 corr_valid_out,
  input  logic [OW-1:0]        corr_bit_offset,
  input  logic [WW-1:0]        corr_weight,
  input  logic [3:0]           corr_rotation,
  output logic                 result_valid,
  output logic                 locked,
  output logic [OW-1:0]        lock_offset,
  output logic [3:0]           lock_rotation,
  output logic                 timeout_err
);

  localparam int N  = BITS_PER_FRAME * NUM_FRAMES;
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] AGREE_MAX = CW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_LIMIT);
  localparam logic [WW-1:0] THRESH_W  = WW'(LOCK_THRESH);

  function automatic logic [CW-1:0] sat_inc_agree(input logic [CW-1:0] v);
    return (v >= AGREE_MAX) ? AGREE_MAX : v + CW'(1);
  endfunction

  function automatic logic [MW-1:0] sat_inc_miss(input logic [MW-1:0] v);
    return (v >= MISS_MAX) ? MISS_MAX : v + MW'(1);
  endfunction

  uw_seq_state_t state, state_nxt;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] wait_cnt;
  logic          ready_q, corr_rst_q, timeout_q, result_valid_q;
  logic          wr_en, rd_en, timeout_hit, latch_en;
  logic          rd_bit_p1, rd_vld_p1;

  logic [OW-1:0] lat_offset;
  logic [WW-1:0] lat_weight;
  logic [3:0]    lat_rot;

  logic [OW-1:0] cand_off, cand_off_nxt, lock_off_nxt;
  logic [3:0]    cand_rot, cand_rot_nxt, lock_rot_nxt;
  logic [CW-1:0] agree_cnt, agree_nxt;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic          locked_nxt, is_match, is_same;

  uw_bit_buffer #(.DEPTH(N), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (up.hard_inp),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_bit_p1)
  );

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    timeout_hit = 1'b0;
    latch_en    = 1'b0;
    case (state)
      ST_FILL: begin
        if (up.valid_in && ready_q) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_ADDR) state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (corr_ready_rx) state_nxt = ST_REPLAY;
      end
      ST_REPLAY: begin
        rd_en = 1'b1;
        if (rd_ptr == LAST_ADDR) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (corr_valid_out) begin
          latch_en  = 1'b1;
          state_nxt = ST_EVAL;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_FILL;
        end
      end
      ST_EVAL: state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  // Hysteresis update; only EVAL touches the lock outputs, a timeout only bumps the miss count.
  always_comb begin
    agree_nxt    = agree_cnt;
    miss_nxt     = miss_cnt;
    cand_off_nxt = cand_off;
    cand_rot_nxt = cand_rot;
    locked_nxt   = locked;
    lock_off_nxt = lock_offset;
    lock_rot_nxt = lock_rotation;
    is_match     = (lat_weight >= THRESH_W);
    is_same      = (lat_offset == cand_off) && (lat_rot == cand_rot);
    if (state == ST_EVAL) begin
      if (is_match && is_same) begin
        agree_nxt = sat_inc_agree(agree_cnt);
        miss_nxt  = '0;
      end else if (is_match) begin
        cand_off_nxt = lat_offset;
        cand_rot_nxt = lat_rot;
        agree_nxt    = CW'(1);
        if (locked) miss_nxt = sat_inc_miss(miss_cnt);
      end else begin
        miss_nxt = sat_inc_miss(miss_cnt);
      end
      if (is_match && (agree_nxt >= AGREE_MAX)) begin
        locked_nxt   = 1'b1;
        lock_off_nxt = cand_off_nxt;
        lock_rot_nxt = cand_rot_nxt;
      end
      if (locked && (miss_nxt >= MISS_MAX)) begin
        locked_nxt = 1'b0;
        agree_nxt  = '0;
        miss_nxt   = '0;
      end
    end else if (timeout_hit) begin
      miss_nxt = sat_inc_miss(miss_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in_n) begin
      state          <= ST_FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      wait_cnt       <= '0;
      ready_q        <= 1'b0;
      rd_vld_p1      <= 1'b0;
      corr_rst_q     <= 1'b1;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
      agree_cnt      <= '0;
      miss_cnt       <= '0;
      cand_off       <= '0;
      cand_rot       <= '0;
      locked         <= 1'b0;
      lock_offset    <= '0;
      lock_rotation  <= '0;
    end else begin
      state          <= state_nxt;
      ready_q        <= (state_nxt == ST_FILL);
      rd_vld_p1      <= rd_en;
      corr_rst_q     <= timeout_hit;
      timeout_q      <= timeout_hit;
      result_valid_q <= (state == ST_EVAL);
      if (wr_en) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
      wait_cnt       <= ((state == ST_WAIT) && (state_nxt == ST_WAIT)) ? wait_cnt + TW'(1) : '0;
      agree_cnt      <= agree_nxt;
      miss_cnt       <= miss_nxt;
      cand_off       <= cand_off_nxt;
      cand_rot       <= cand_rot_nxt;
      locked         <= locked_nxt;
      lock_offset    <= lock_off_nxt;
      lock_rotation  <= lock_rot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      lat_offset <= corr_bit_offset;
      lat_weight <= corr_weight;
      lat_rot    <= corr_rotation;
    end
  end

  // p1: buffer read data and its valid leave together; data gated so idle/reset shows 0.
  assign corr_bit     = rd_bit_p1 & rd_vld_p1;
  assign corr_valid   = rd_vld_p1;
  assign corr_rst     = corr_rst_q;
  assign timeout_err  = timeout_q;
  assign result_valid = result_valid_q;
  assign up.ready_out = ready_q;

endmodule

// File: tb/tb_uw_sync_sequencer.sv
// Scoreboard bench: stimulus pushes expected replay bits / sync results, a monitor pops and compares.
module tb_uw_sync_sequencer;

  localparam int BPF = 80;
  localparam int NF  = 4;
  localparam int N   = BPF * NF;
  localparam int TMO = 256;

  typedef struct packed {
    logic       lk;
    logic [6:0] off;
    logic [3:0] rot;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_in_n;
  logic       corr_bit, corr_valid, corr_rst;
  logic       corr_ready_rx, corr_valid_out;
  logic [6:0] corr_bit_offset;
  logic [8:0] corr_weight;
  logic [3:0] corr_rotation;
  logic       result_valid, locked, timeout_err;
  logic [6:0] lock_offset;
  logic [3:0] lock_rotation;

  uw_sync_sequencer_if up ();

  uw_sync_sequencer #(.BITS_PER_FRAME(BPF), .NUM_FRAMES(NF), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_in_n        (rst_in_n),
    .up              (up),
    .corr_bit        (corr_bit),
    .corr_valid      (corr_valid),
    .corr_rst        (corr_rst),
    .corr_ready_rx   (corr_ready_rx),
    .corr_valid_out  (corr_valid_out),
    .corr_bit_offset (corr_bit_offset),
    .corr_weight     (corr_weight),
    .corr_rotation   (corr_rotation),
    .result_valid    (result_valid),
    .locked          (locked),
    .lock_offset     (lock_offset),
    .lock_rotation   (lock_rotation),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_bits [$];
  res_t exp_res [$];
  int   exp_to = 0;
  int   res_seen = 0;
  int   to_seen = 0;
  int   run = 0;
  int   cyc = 0;
  int   last_vld = 0;

  logic [6:0] rsp_off;
  logic [3:0] rsp_rot;
  logic [8:0] rsp_wt;
  logic       rsp_silent = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  // Correlator model: answers a fixed delay after a complete N-bit burst unless silenced.
  initial begin
    int mcnt, dly;
    corr_valid_out = 1'b0; corr_bit_offset = '0; corr_weight = '0; corr_rotation = '0;
    mcnt = 0; dly = -1;
    forever begin
      @(negedge clk);
      corr_valid_out = 1'b0;
      if (!rst_in_n) begin
        mcnt = 0; dly = -1;
      end else if (corr_valid) begin
        mcnt++;
        if (mcnt == N) begin
          mcnt = 0;
          dly  = rsp_silent ? -1 : 3;
        end
      end else if (dly > 0) begin
        dly--;
      end else if (dly == 0) begin
        corr_valid_out  = 1'b1;
        corr_bit_offset = rsp_off;
        corr_rotation   = rsp_rot;
        corr_weight     = rsp_wt;
        dly = -1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic to_follow;
    logic e;
    res_t r;
    to_follow = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_in_n) begin
        run = 0;
        to_follow = 1'b0;
      end else begin
        if (to_follow) begin
          chk("timeout_err_width", timeout_err, 0);
          chk("corr_rst_width", corr_rst, 0);
          to_follow = 1'b0;
        end
        if (corr_valid) begin
          run++;
          last_vld = cyc;
          if (exp_bits.size() == 0) fail_evt("replay_extra_bit");
          else begin
            e = exp_bits.pop_front();
            chk("replay_bit", corr_bit, e);
          end
        end else if (run != 0) begin
          chk("burst_len", run, N);
          run = 0;
        end
        if (result_valid) begin
          res_seen++;
          if (exp_res.size() == 0) fail_evt("result_unexpected");
          else begin
            r = exp_res.pop_front();
            chk("locked", locked, r.lk);
            chk("lock_offset", lock_offset, r.off);
            chk("lock_rotation", lock_rotation, r.rot);
          end
        end
        if (timeout_err) begin
          to_seen++;
          if (exp_to == 0) fail_evt("timeout_unexpected");
          else begin
            exp_to--;
            chk("timeout_delay", cyc - last_vld, TMO);
            chk("timeout_corr_rst", corr_rst, 1);
            chk("timeout_ready", up.ready_out, 1);
            to_follow = 1'b1;
          end
        end
      end
    end
  end

  task automatic feed_window();
    logic b, acc;
    int   w;
    for (int i = 0; i < N; i++) begin
      b = 1'($urandom_range(0, 1));
      while ($urandom_range(0, 99) < 30) begin
        up.valid_in = 1'b0;
        @(negedge clk);
      end
      up.valid_in = 1'b1;
      up.hard_inp = b;
      acc = 1'b0;
      w = 0;
      while (!acc) begin
        acc = up.ready_out;
        @(negedge clk);
        w++;
        if (w > 4 * N + TMO) begin
          $display("FAIL feed_stall: bit %0d never accepted", i);
          $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
          $fatal(1, "upstream stalled");
        end
      end
      exp_bits.push_back(b);
    end
    up.valid_in = 1'b0;
  endtask

  task automatic wait_done();
    int base, w;
    base = res_seen + to_seen;
    w = 0;
    while ((res_seen + to_seen) == base && w < 3 * N + TMO + 200) begin
      @(negedge clk);
      w++;
    end
    if ((res_seen + to_seen) == base) begin
      n_chk++;
      n_err++;
      $display("FAIL window_done: no result after %0d cycles, expected one", w);
    end
  endtask

  task automatic run_window(input logic [6:0] off, input logic [3:0] rot, input logic [8:0] wt,
                            input logic silent, input res_t exp, input int arm_hold);
    rsp_off = off; rsp_rot = rot; rsp_wt = wt; rsp_silent = silent;
    if (silent) exp_to++;
    else exp_res.push_back(exp);
    if (arm_hold > 0) corr_ready_rx = 1'b0;
    feed_window();
    chk("ready_drop", up.ready_out, 0);
    if (arm_hold > 0) begin
      repeat (arm_hold) begin
        @(negedge clk);
        chk("arm_hold_valid", corr_valid, 0);
      end
      corr_ready_rx = 1'b1;
    end
    wait_done();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", up.ready_out, 0);
    chk("rst_corr_valid", corr_valid, 0);
    chk("rst_corr_bit", corr_bit, 0);
    chk("rst_corr_rst", corr_rst, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lock_offset", lock_offset, 0);
    chk("rst_lock_rotation", lock_rotation, 0);
  endtask

  initial begin
    int w;
    rst_in_n = 1'b0; up.valid_in = 1'b0; up.hard_inp = 1'b0; corr_ready_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_in_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", up.ready_out, 1);
    chk("post_rst_corr_rst", corr_rst, 0);

    // Lock acquisition (first window also holds the correlator not-ready in ARM)
    run_window(7'd17, 4'd2, 9'd250, 1'b0, '{1'b0, 7'd0,  4'd0}, 12);
    run_window(7'd17, 4'd2, 9'd250, 1'b0, '{1'b0, 7'd0,  4'd0}, 0);
    run_window(7'd17, 4'd2, 9'd250, 1'b0, '{1'b1, 7'd17, 4'd2}, 0);
    // Single weak result (just below threshold) keeps lock
    run_window(7'd17, 4'd2, 9'd223, 1'b0, '{1'b1, 7'd17, 4'd2}, 0);
    run_window(7'd17, 4'd2, 9'd250, 1'b0, '{1'b1, 7'd17, 4'd2}, 0);
    // Two consecutive weak results drop lock in the second EVAL
    run_window(7'd17, 4'd2, 9'd100, 1'b0, '{1'b1, 7'd17, 4'd2}, 0);
    run_window(7'd17, 4'd2, 9'd100, 1'b0, '{1'b0, 7'd17, 4'd2}, 0);
    // Candidate change restarts agreement: no lock after three matches
    run_window(7'd17, 4'd2, 9'd250, 1'b0, '{1'b0, 7'd17, 4'd2}, 0);
    run_window(7'd17, 4'd2, 9'd224, 1'b0, '{1'b0, 7'd17, 4'd2}, 0);
    run_window(7'd40, 4'd1, 9'd250, 1'b0, '{1'b0, 7'd17, 4'd2}, 0);
    // Correlator timeout
    run_window(7'd40, 4'd1, 9'd250, 1'b1, '{1'b0, 7'd0, 4'd0}, 0);

    // Reset in the middle of a replay burst
    rsp_silent = 1'b0;
    feed_window();
    w = 0;
    while (run < 200 && w < 2 * N) begin
      @(posedge clk);
      w++;
    end
    chk("replay_reached_200", (run >= 200) ? 1 : 0, 1);
    #1 rst_in_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    exp_bits.delete();
    rst_in_n = 1'b1;
    @(negedge clk);
    chk("post_rst2_ready", up.ready_out, 1);
    chk("post_rst2_corr_rst", corr_rst, 0);
    run_window(7'd40, 4'd1, 9'd250, 1'b0, '{1'b0, 7'd0, 4'd0}, 0);
    run_window(7'd40, 4'd1, 9'd250, 1'b0, '{1'b0, 7'd0, 4'd0}, 0);

    repeat (5) @(negedge clk);
    chk("leftover_bits", exp_bits.size(), 0);
    chk("leftover_results", exp_res.size(), 0);
    chk("leftover_timeouts", exp_to, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
